// File: rtl/vwq_pkg.sv
// Shared types for the vblank write queue.
// Optional VWQ_FILL_EN adds a per-entry repeat length.
package vwq_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        WAIT_BLANK = 2'd0,
        DRAIN      = 2'd1,
        DONE       = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
`ifdef VWQ_FILL_EN
        logic [7:0]        len;
`endif
    } entry_t;

endpackage

// File: rtl/vwq_fifo.sv
// Single-clock command FIFO; head is read combinationally from the read pointer.
module vwq_fifo
    import vwq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 push_entry,
    input  logic                   pop,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: reset only has to discard, which the pointers do.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/vblank_write_queue.sv
// Buffers bus writes and replays them only while vsync is high.
// Optional VWQ_FILL_EN: each entry repeats its data over len+1 consecutive addresses.
//   state      | meaning
//   WAIT_BLANK | idle, waiting for vsync rising edge
//   DRAIN      | blanking, issuing queued writes
//   DONE       | blanking, write budget spent
module vblank_write_queue
    import vwq_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int BUDGET = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [DATA_W-1:0]      cmd_data,
`ifdef VWQ_FILL_EN
    input  logic [7:0]             cmd_len,
`endif
    input  logic                   vsync,
    output logic [ADDR_W-1:0]      bus_addr,
    output logic [DATA_W-1:0]      bus_data,
    output logic                   bus_rw,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy
);

    state_t            state;
    logic              vsync_q;
    logic              blank_start;
    logic              budget_ok;
    logic              budget_hit;
    logic              issue;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [8:0]        issued;
    logic [ADDR_W-1:0] wr_addr;
    entry_t            head;
    entry_t            push_entry;

    assign cmd_ready   = !full;
    assign push        = cmd_valid && cmd_ready;
    assign blank_start = vsync && !vsync_q;
    assign budget_ok   = (BUDGET == 0) || (int'(issued) < BUDGET);
    assign budget_hit  = (BUDGET != 0) && !budget_ok;
    assign issue       = (state == DRAIN) && vsync && !empty && budget_ok;
    assign busy        = (state == DRAIN);

    assign push_entry.addr = cmd_addr;
    assign push_entry.data = cmd_data;

`ifdef VWQ_FILL_EN
    logic [7:0] offset;

    assign push_entry.len = cmd_len;
    assign pop            = issue && (offset == head.len);
    assign wr_addr        = head.addr + {8'd0, offset};

    // Offset survives a paused fill so the next blank resumes mid-entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            offset <= '0;
        end else if (pop) begin
            offset <= '0;
        end else if (issue) begin
            offset <= offset + 8'd1;
        end
    end
`else
    assign pop     = issue;
    assign wr_addr = head.addr;
`endif

    vwq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .level      (level),
        .full       (full),
        .empty      (empty)
    );

    // vsync_q resets high so a blank already in progress at reset release is skipped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= WAIT_BLANK;
            vsync_q  <= 1'b1;
            issued   <= '0;
            bus_addr <= '0;
            bus_data <= '0;
            bus_rw   <= 1'b0;
        end else begin
            vsync_q <= vsync;
            bus_rw  <= 1'b0;
            case (state)
                WAIT_BLANK: begin
                    if (blank_start) begin
                        state  <= DRAIN;
                        issued <= '0;
                    end
                end
                DRAIN: begin
                    if (issue) begin
                        bus_addr <= wr_addr;
                        bus_data <= head.data;
                        bus_rw   <= 1'b1;
                        if (issued != '1) begin
                            issued <= issued + 9'd1;
                        end
                    end
                    if (!vsync) begin
                        state <= WAIT_BLANK;
                    end else if (budget_hit) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!vsync) begin
                        state <= WAIT_BLANK;
                    end
                end
                default: state <= WAIT_BLANK;
            endcase
        end
    end

endmodule

// File: tb/tb_vblank_write_queue.sv
// Directed bench: dut0 has no write budget, dut1 a budget of 4; both share stimulus.
// With VWQ_FILL_EN defined the fill/wrap sequences also run.
module tb_vblank_write_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_data;
`ifdef VWQ_FILL_EN
    logic [7:0]  cmd_len;
`endif
    logic        vsync;

    logic        ready0, rw0, busy0, ready1, rw1, busy1;
    logic [15:0] addr0, addr1;
    logic [7:0]  data0, data1;
    logic [4:0]  level0, level1;

    int          n_vec = 0;
    int          n_err = 0;
    logic [23:0] log0[$];
    logic [23:0] log1[$];

    always #5 clk = ~clk;

    vblank_write_queue #(.DEPTH(16), .BUDGET(0)) dut0 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready0),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
`ifdef VWQ_FILL_EN
        .cmd_len(cmd_len),
`endif
        .vsync(vsync), .bus_addr(addr0), .bus_data(data0), .bus_rw(rw0),
        .level(level0), .busy(busy0)
    );

    vblank_write_queue #(.DEPTH(16), .BUDGET(4)) dut1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready1),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
`ifdef VWQ_FILL_EN
        .cmd_len(cmd_len),
`endif
        .vsync(vsync), .bus_addr(addr1), .bus_data(data1), .bus_rw(rw1),
        .level(level1), .busy(busy1)
    );

    // Bus write logs, sampled at the active edge (pre-update values).
    always @(posedge clk) begin
        if (rw0) log0.push_back({addr0, data0});
        if (rw1) log1.push_back({addr1, data1});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] log_at(input logic [23:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 24'hxxxxxx;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [15:0] a, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
`ifdef VWQ_FILL_EN
        cmd_len   = 8'd0;
`endif
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

`ifdef VWQ_FILL_EN
    task automatic push_fill(input logic [15:0] a, input logic [7:0] d, input logic [7:0] l);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_len   = l;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_len   = 8'd0;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
`ifdef VWQ_FILL_EN
        cmd_len   = '0;
`endif
        vsync     = 1'b0;
        cycles(2);

        check("rst_ready", ready0, 1);
        check("rst_addr",  addr0,  0);
        check("rst_data",  data0,  0);
        check("rst_rw",    rw0,    0);
        check("rst_level", level0, 0);
        check("rst_busy",  busy0,  0);
        reset = 1'b0;
        cycles(2);

        // Three writes queued outside blank, drained back-to-back once vsync rises
        push(16'hFC05, 8'h41);
        push(16'hFBF8, 8'h50);
        push(16'hFE03, 8'h09);
        check("t1_level3", level0, 3);
        cycles(3);
        check("t1_no_early_rw", log0.size(), 0);
        vsync = 1'b1;
        cycles(1);
        check("t1_busy", busy0, 1);
        check("t1_rw_lat", rw0, 0);
        cycles(1);
        check("t1_rw_a", rw0, 1);
        check("t1_wr_a", {addr0, data0}, 24'hFC0541);
        cycles(1);
        check("t1_rw_b", rw0, 1);
        check("t1_wr_b", {addr0, data0}, 24'hFBF850);
        cycles(1);
        check("t1_rw_c", rw0, 1);
        check("t1_wr_c", {addr0, data0}, 24'hFE0309);
        cycles(1);
        check("t1_rw_end", rw0, 0);
        check("t1_level0", level0, 0);
        check("t1_hold_addr", addr0, 16'hFE03);
        vsync = 1'b0;
        cycles(2);
        check("t1_idle", busy0, 0);

        // Reset discards entries; vsync high across reset release does not start a drain
        log0.delete();
        push(16'h1111, 8'h11);
        push(16'h2222, 8'h22);
        vsync = 1'b1;
        reset = 1'b1;
        cycles(1);
        check("t2_discard", level0, 0);
        reset = 1'b0;
        push(16'hFC10, 8'hA1);
        push(16'hFBF0, 8'hB2);
        cycles(8);
        check("t2_no_writes", log0.size(), 0);
        check("t2_level2", level0, 2);
        check("t2_not_busy", busy0, 0);
        vsync = 1'b0;
        cycles(2);
        vsync = 1'b1;
        cycles(6);
        check("t2_count", log0.size(), 2);
        check("t2_wr0", log_at(log0, 0), 24'hFC10A1);
        check("t2_wr1", log_at(log0, 1), 24'hFBF0B2);
        check("t2_level0", level0, 0);
        vsync = 1'b0;
        cycles(2);

        // Full FIFO: extra push refused; pop while full still shows not-ready that cycle
        log0.delete();
        for (int i = 0; i < 16; i++) push(16'(16'hFC20 + i), 8'(8'h60 + i));
        check("t3_level16", level0, 16);
        check("t3_ready_full", ready0, 0);
        cmd_valid = 1'b1;
        cmd_addr  = 16'h0BAD;
        cmd_data  = 8'hEE;
        cycles(3);
        check("t3_17th_rejected", level0, 16);
        vsync = 1'b1;
        cycles(1);
        check("t3_ready_low_pop", ready0, 0);
        check("t3_level_pre_pop", level0, 16);
        cycles(1);
        check("t3_no_push_on_pop", level0, 15);
        check("t3_first_rw", rw0, 1);
        cmd_valid = 1'b0;
        cycles(20);
        check("t3_count", log0.size(), 16);
        for (int i = 0; i < 16; i++)
            check("t3_order", log_at(log0, i), {16'(16'hFC20 + i), 8'(8'h60 + i)});
        check("t3_level0", level0, 0);
        vsync = 1'b0;
        cycles(2);

        // vsync falls after two of five writes; the rest follow in the next blank
        log0.delete();
        for (int i = 0; i < 5; i++) push(16'(16'hFC40 + i), 8'(8'h70 + i));
        vsync = 1'b1;
        cycles(3);
        vsync = 1'b0;
        cycles(4);
        check("t4_two_issued", log0.size(), 2);
        check("t4_level3", level0, 3);
        check("t4_idle", busy0, 0);
        vsync = 1'b1;
        cycles(8);
        vsync = 1'b0;
        cycles(2);
        check("t4_count", log0.size(), 5);
        for (int i = 0; i < 5; i++)
            check("t4_order", log_at(log0, i), {16'(16'hFC40 + i), 8'(8'h70 + i)});

        // Budget of 4: ten entries drain 4, 4, 2 over three blanks
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(1);
        log0.delete();
        log1.delete();
        for (int i = 0; i < 10; i++) push(16'(16'hFBF0 + i), 8'(8'h80 + i));
        vsync = 1'b1;
        cycles(12);
        check("t5_blank1_writes", log1.size(), 4);
        check("t5_blank1_level", level1, 6);
        check("t5_done_state", busy1, 0);
        check("t5_unlimited_all", level0, 0);
        vsync = 1'b0;
        cycles(2);
        vsync = 1'b1;
        cycles(12);
        check("t5_blank2_writes", log1.size(), 8);
        check("t5_blank2_level", level1, 2);
        vsync = 1'b0;
        cycles(2);
        vsync = 1'b1;
        cycles(12);
        check("t5_blank3_writes", log1.size(), 10);
        check("t5_blank3_level", level1, 0);
        check("t5_under_budget", busy1, 1);
        vsync = 1'b0;
        cycles(2);
        for (int i = 0; i < 10; i++)
            check("t5_order", log_at(log1, i), {16'(16'hFBF0 + i), 8'(8'h80 + i)});

`ifdef VWQ_FILL_EN
        // 101 high cycles: the first is the edge-detect cycle, the other 100 each write
        log0.delete();
        push_fill(16'hFC00, 8'h20, 8'd255);
        vsync = 1'b1;
        cycles(101);
        vsync = 1'b0;
        cycles(3);
        check("f1_paused_count", log0.size(), 100);
        check("f1_first", log_at(log0, 0), 24'hFC0020);
        check("f1_last", log_at(log0, 99), 24'hFC6320);
        check("f1_entry_kept", level0, 1);
        vsync = 1'b1;
        cycles(200);
        vsync = 1'b0;
        cycles(3);
        check("f1_total", log0.size(), 256);
        check("f1_resume", log_at(log0, 100), 24'hFC6420);
        check("f1_end", log_at(log0, 255), 24'hFCFF20);
        check("f1_popped", level0, 0);

        log0.delete();
        push_fill(16'hFFFE, 8'h5A, 8'd3);
        vsync = 1'b1;
        cycles(10);
        vsync = 1'b0;
        cycles(2);
        check("f2_count", log0.size(), 4);
        check("f2_w0", log_at(log0, 0), 24'hFFFE5A);
        check("f2_w1", log_at(log0, 1), 24'hFFFF5A);
        check("f2_w2", log_at(log0, 2), 24'h00005A);
        check("f2_w3", log_at(log0, 3), 24'h00015A);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
